idma_legalizer_r_axi_w_obi_be: RTL and testbench
================================================

IDMA_LEGALIZER_R_AXI_W_OBI_BE -- requirements
Module: idma_legalizer_r_axi_w_obi_be

Interface
REQ-001 SHALL have parameter DataWidth, default 32: data bus width in bits, power of two, at least 16; StrbWidth = DataWidth/8; OffW = log2(StrbWidth).
REQ-002 SHALL have parameter AddrWidth, default 32: byte address width.
REQ-003 SHALL have parameter LenWidth, default 32: transfer length width in bytes.
REQ-004 SHALL have parameter MaxAxiBeats, default 16: maximum AR beats per burst, range 1..256.
REQ-005 SHALL have parameter PageSize, default 4096: read page boundary in bytes, power of two, at least MaxAxiBeats*StrbWidth.
REQ-006 SHALL have parameter IdWidth, default 4: transfer ID width.
REQ-007 SHALL have the following ports, as name, direction, width, meaning:
- clk_i, in, 1: the single clock.
- rst_ni, in, 1: asynchronous active-low reset.
- req_valid_i / req_ready_o, in/out, 1: 1D request handshake.
- req_src_addr_i / req_dst_addr_i, in, AddrWidth: source and destination byte addresses.
- req_length_i, in, LenWidth: transfer length in bytes.
- req_id_i, in, IdWidth: transfer ID.
- req_last_i, in, 1: midend super-last flag.
- ar_valid_o / ar_ready_i, out/in, 1: AXI AR handshake.
- ar_addr_o, out, AddrWidth: word-aligned read address.
- ar_len_o, out, 8: AXI burst length, equal to beats minus 1.
- ar_id_o, out, IdWidth: read ID.
- r_offset_o / r_tailer_o, out, OffW: first-beat and last-beat byte offsets.
- r_shift_o / w_shift_o, out, OffW: read and write shift amounts.
- obi_valid_o / obi_ready_i, out/in, 1: OBI write request handshake.
- obi_addr_o, out, AddrWidth: word-aligned write address.
- obi_be_o, out, StrbWidth: byte enables.
- obi_aid_o, out, IdWidth: write ID.
- obi_last_o, out, 1: final write word of the transfer.
- obi_super_last_o, out, 1: registered req_last_i.
- flush_i, in, 1: stall emission.
- kill_i, in, 1: abort the active transfer.
- r_busy_o / w_busy_o, out, 1: read and write machines active.

Function
REQ-008 SHALL keep independent read and write machines, each with states IDLE and ACTIVE; r_busy_o and w_busy_o SHALL equal their machine's ACTIVE state.
REQ-009 SHALL assert req_ready_o exactly when both machines are IDLE and flush_i=0 and kill_i=0.
REQ-010 On acceptance of a non-zero-length request, both machines SHALL enter ACTIVE, and the first ar_valid_o/obi_valid_o SHALL assert in the next cycle.
REQ-011 SHALL consume a zero-length request without any AR or OBI emission; both machines SHALL stay IDLE.
REQ-012 On acceptance, SHALL latch ID and req_last_i, with r_shift_o = src[OffW-1:0] and w_shift_o = (StrbWidth - dst[OffW-1:0]) mod StrbWidth; these values SHALL hold until the next acceptance.
REQ-013 Read burst size in bytes SHALL be nr = min(remaining, bytes to next PageSize boundary, MaxAxiBeats*StrbWidth - offset), where offset = addr[OffW-1:0].
REQ-014 ar_addr_o SHALL be addr with its low OffW bits cleared.
REQ-015 ar_len_o SHALL be ((nr + offset - 1) >> OffW).
REQ-016 r_offset_o SHALL equal offset; r_tailer_o SHALL equal (offset + nr) mod StrbWidth.
REQ-017 Each write word SHALL carry nw = min(remaining, StrbWidth - offset) bytes; obi_be_o bits offset..offset+nw-1 SHALL be set and all other bits clear.
REQ-018 obi_last_o SHALL be 1 exactly when nw equals the remaining write bytes.
REQ-019 On each AR or OBI handshake, that machine SHALL advance addr by its byte count and reduce remaining by the same amount; when remaining reaches 0 it SHALL return to IDLE.
REQ-020 Read and write machines SHALL progress independently; backpressure on one side SHALL NOT stall the other.
REQ-021 While flush_i=1, ar_valid_o and obi_valid_o SHALL be 0 and neither machine SHALL change state.
REQ-022 kill_i=1 SHALL return both machines to IDLE on the next edge with remaining cleared; kill_i SHALL take priority over flush_i and over handshakes.
REQ-023 Address arithmetic SHALL wrap modulo 2^AddrWidth.
REQ-024 While valid=1 and ready=0 with no kill_i or flush_i, all payload outputs SHALL be stable.

Reset
REQ-025 Asynchronous reset (rst_ni=0) SHALL force both machines IDLE and all state registers to 0, including mid-transfer.
REQ-026 During reset, req_ready_o, ar_valid_o, obi_valid_o, r_busy_o, w_busy_o, obi_last_o and obi_super_last_o SHALL be 0, as SHALL every other output.

Verification
REQ-027 Unaligned transfer, defaults: src=0x1002, dst=0x2001, len=10 -> one AR (0x1000, len 2, r_offset 2, r_tailer 0); OBI words 0x2000/be 1110, 0x2004/be 1111, 0x2008/be 0111 with last on the third; r_shift=2, w_shift=3.
REQ-028 Read page crossing: src=0x0FF8, len=16 -> AR (0x0FF8, len 1), then AR (0x1000, len 1).
REQ-029 Burst cap: src=0x0, len=100 -> AR (0x0, len 15), then AR (0x40, len 8).
REQ-030 Backpressure: obi_ready_i=0 for 5 cycles mid-transfer -> OBI payload stable throughout, AR emission continues, no bytes lost or duplicated.
REQ-031 Kill or flush: kill_i pulsed after the first OBI handshake -> busy outputs 0 next cycle and req_ready_o=1; flush_i held 3 cycles -> no valid asserted and state unchanged.
REQ-032 Reset mid-transfer -> all outputs 0 immediately; a new request is accepted correctly after rst_ni rises.

Source files
------------

// File: rtl/idma_legalizer_r_axi_w_obi_be_if.sv
// Bus bundle for the AXI-read / OBI-write legalizer: request, AR, OBI,
// flow control and status. The slave modport is the legalizer side.
interface idma_legalizer_r_axi_w_obi_be_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned LenWidth  = 32,
    parameter int unsigned IdWidth   = 4
) ();
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned OffW      = $clog2(StrbWidth);

    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [AddrWidth-1:0] req_src_addr_i;
    logic [AddrWidth-1:0] req_dst_addr_i;
    logic [LenWidth-1:0]  req_length_i;
    logic [IdWidth-1:0]   req_id_i;
    logic                 req_last_i;

    logic                 ar_valid_o;
    logic                 ar_ready_i;
    logic [AddrWidth-1:0] ar_addr_o;
    logic [7:0]           ar_len_o;
    logic [IdWidth-1:0]   ar_id_o;
    logic [OffW-1:0]      r_offset_o;
    logic [OffW-1:0]      r_tailer_o;
    logic [OffW-1:0]      r_shift_o;
    logic [OffW-1:0]      w_shift_o;

    logic                 obi_valid_o;
    logic                 obi_ready_i;
    logic [AddrWidth-1:0] obi_addr_o;
    logic [StrbWidth-1:0] obi_be_o;
    logic [IdWidth-1:0]   obi_aid_o;
    logic                 obi_last_o;
    logic                 obi_super_last_o;

    logic                 flush_i;
    logic                 kill_i;
    logic                 r_busy_o;
    logic                 w_busy_o;

    modport slave (
        input  req_valid_i, req_src_addr_i, req_dst_addr_i, req_length_i, req_id_i, req_last_i,
        output req_ready_o,
        output ar_valid_o, ar_addr_o, ar_len_o, ar_id_o, r_offset_o, r_tailer_o, r_shift_o, w_shift_o,
        input  ar_ready_i,
        output obi_valid_o, obi_addr_o, obi_be_o, obi_aid_o, obi_last_o, obi_super_last_o,
        input  obi_ready_i,
        input  flush_i, kill_i,
        output r_busy_o, w_busy_o
    );

    modport master (
        output req_valid_i, req_src_addr_i, req_dst_addr_i, req_length_i, req_id_i, req_last_i,
        input  req_ready_o,
        input  ar_valid_o, ar_addr_o, ar_len_o, ar_id_o, r_offset_o, r_tailer_o, r_shift_o, w_shift_o,
        output ar_ready_i,
        input  obi_valid_o, obi_addr_o, obi_be_o, obi_aid_o, obi_last_o, obi_super_last_o,
        output obi_ready_i,
        output flush_i, kill_i,
        input  r_busy_o, w_busy_o
    );
endinterface

// File: rtl/idma_legalizer_r_axi_w_obi_be.sv
// Splits a 1D transfer into page/burst-legal AXI read bursts and word-sized
// OBI write requests. Read and write sides run independently once started.
module idma_legalizer_r_axi_w_obi_be #(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned LenWidth    = 32,
    parameter int unsigned MaxAxiBeats = 16,
    parameter int unsigned PageSize    = 4096,
    parameter int unsigned IdWidth     = 4
) (
    input logic                          clk_i,
    input logic                          rst_ni,
    idma_legalizer_r_axi_w_obi_be_if.slave bus
);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned OffW      = $clog2(StrbWidth);
    localparam int unsigned PgW       = $clog2(PageSize);
    // Wide enough for lengths, page room and burst room without overflow.
    localparam int unsigned CalcW     = ((LenWidth > PgW) ? LenWidth : PgW) + 2;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

    state_e               r_state_q, r_state_d, w_state_q, w_state_d;
    logic [AddrWidth-1:0] r_addr_q, w_addr_q;
    logic [LenWidth-1:0]  r_rem_q, w_rem_q;
    logic [IdWidth-1:0]   id_q;
    logic                 last_q;
    logic [OffW-1:0]      r_shift_q, w_shift_q;

    logic                 r_active, w_active;
    logic                 req_fire, ar_fire, obi_fire;
    logic [OffW-1:0]      r_off, w_off;
    logic [CalcW-1:0]     r_rem_c, page_room, burst_room, nr;
    logic [CalcW-1:0]     w_rem_c, word_room, nw;

    assign r_active = (r_state_q == ACTIVE);
    assign w_active = (w_state_q == ACTIVE);
    assign r_off    = r_addr_q[OffW-1:0];
    assign w_off    = w_addr_q[OffW-1:0];

    // Read burst size: limited by remaining bytes, page boundary and beat cap.
    always_comb begin
        r_rem_c    = CalcW'(r_rem_q);
        page_room  = CalcW'(PageSize) - CalcW'(r_addr_q[PgW-1:0]);
        burst_room = CalcW'(MaxAxiBeats * StrbWidth) - CalcW'(r_off);
        nr         = r_rem_c;
        if (page_room < nr)  nr = page_room;
        if (burst_room < nr) nr = burst_room;
    end

    // Write word size: never crosses a bus word.
    always_comb begin
        w_rem_c   = CalcW'(w_rem_q);
        word_room = CalcW'(StrbWidth) - CalcW'(w_off);
        nw        = (w_rem_c < word_room) ? w_rem_c : word_room;
    end

    // Emission is suppressed while flushing or killing so no handshake can slip through.
    assign bus.ar_valid_o  = r_active & ~bus.flush_i & ~bus.kill_i;
    assign bus.obi_valid_o = w_active & ~bus.flush_i & ~bus.kill_i;
    assign bus.req_ready_o = rst_ni & ~r_active & ~w_active & ~bus.flush_i & ~bus.kill_i;

    assign req_fire = bus.req_valid_i & bus.req_ready_o;
    assign ar_fire  = bus.ar_valid_o & bus.ar_ready_i;
    assign obi_fire = bus.obi_valid_o & bus.obi_ready_i;

    // Payloads come from registers only, so they hold under backpressure.
    assign bus.ar_addr_o  = r_active ? {r_addr_q[AddrWidth-1:OffW], {OffW{1'b0}}} : '0;
    assign bus.ar_len_o   = r_active ? 8'((nr + CalcW'(r_off) - CalcW'(1)) >> OffW) : '0;
    assign bus.r_offset_o = r_active ? r_off : '0;
    assign bus.r_tailer_o = r_active ? OffW'(CalcW'(r_off) + nr) : '0;
    assign bus.ar_id_o    = id_q;
    assign bus.r_shift_o  = r_shift_q;
    assign bus.w_shift_o  = w_shift_q;

    assign bus.obi_addr_o       = w_active ? {w_addr_q[AddrWidth-1:OffW], {OffW{1'b0}}} : '0;
    assign bus.obi_be_o         = w_active ?
        StrbWidth'((((2 * StrbWidth)'(1) << nw) - (2 * StrbWidth)'(1)) << w_off) : '0;
    assign bus.obi_last_o       = w_active & (nw == w_rem_c);
    assign bus.obi_aid_o        = id_q;
    assign bus.obi_super_last_o = last_q;

    assign bus.r_busy_o = r_active;
    assign bus.w_busy_o = w_active;

    // Next-state for both machines: kill beats flush beats handshakes.
    always_comb begin
        r_state_d = r_state_q;
        w_state_d = w_state_q;
        if (bus.kill_i) begin
            r_state_d = IDLE;
            w_state_d = IDLE;
        end else if (!bus.flush_i) begin
            if (req_fire && (bus.req_length_i != '0)) begin
                r_state_d = ACTIVE;
                w_state_d = ACTIVE;
            end
            if (ar_fire && (nr == r_rem_c))            r_state_d = IDLE;
            if (obi_fire && (nw == w_rem_c))           w_state_d = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= IDLE;
            w_state_q <= IDLE;
        end else begin
            r_state_q <= r_state_d;
            w_state_q <= w_state_d;
        end
    end

    // Transfer bookkeeping: latch on acceptance, advance on each handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr_q  <= '0;
            w_addr_q  <= '0;
            r_rem_q   <= '0;
            w_rem_q   <= '0;
            id_q      <= '0;
            last_q    <= 1'b0;
            r_shift_q <= '0;
            w_shift_q <= '0;
        end else if (bus.kill_i) begin
            r_rem_q <= '0;
            w_rem_q <= '0;
        end else if (!bus.flush_i) begin
            if (req_fire) begin
                r_addr_q  <= bus.req_src_addr_i;
                w_addr_q  <= bus.req_dst_addr_i;
                r_rem_q   <= bus.req_length_i;
                w_rem_q   <= bus.req_length_i;
                id_q      <= bus.req_id_i;
                last_q    <= bus.req_last_i;
                r_shift_q <= bus.req_src_addr_i[OffW-1:0];
                w_shift_q <= OffW'(0) - bus.req_dst_addr_i[OffW-1:0];
            end else begin
                if (ar_fire) begin
                    r_addr_q <= r_addr_q + AddrWidth'(nr);
                    r_rem_q  <= r_rem_q - LenWidth'(nr);
                end
                if (obi_fire) begin
                    w_addr_q <= w_addr_q + AddrWidth'(nw);
                    w_rem_q  <= w_rem_q - LenWidth'(nw);
                end
            end
        end
    end
endmodule

// File: tb/tb_idma_legalizer_r_axi_w_obi_be.sv
// Scoreboard bench for the AXI-read / OBI-write legalizer.
module tb_idma_legalizer_r_axi_w_obi_be;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    idma_legalizer_r_axi_w_obi_be_if #(.DataWidth(32), .AddrWidth(32), .LenWidth(32), .IdWidth(4)) bus ();

    idma_legalizer_r_axi_w_obi_be #(
        .DataWidth(32), .AddrWidth(32), .LenWidth(32),
        .MaxAxiBeats(16), .PageSize(4096), .IdWidth(4)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.slave)
    );

    typedef struct { logic [31:0] addr; logic [7:0] len; logic [1:0] off; logic [1:0] tail; } ar_t;
    typedef struct { logic [31:0] addr; logic [3:0] be; logic last; } obi_t;

    ar_t  ar_q[$];
    obi_t obi_q[$];
    int   checks = 0;
    int   failures = 0;
    int   ar_hs = 0;
    int   obi_hs = 0;

    logic [3:0] cur_id = '0;
    logic       cur_last = 1'b0;
    logic [1:0] cur_rsh = '0;
    logic [1:0] cur_wsh = '0;

    logic rand_rdy = 1'b0, ar_man = 1'b0, obi_man = 1'b0, ar_rnd = 1'b0, obi_rnd = 1'b0;
    assign bus.ar_ready_i  = rand_rdy ? ar_rnd  : ar_man;
    assign bus.obi_ready_i = rand_rdy ? obi_rnd : obi_man;

    always @(posedge clk) begin
        #1;
        ar_rnd  = ($urandom % 4) != 0;
        obi_rnd = ($urandom % 4) != 0;
    end

    // Reference: byte-level splitting into legal bursts and bus words.
    function automatic void model(input logic [31:0] src, input logic [31:0] dst, input int unsigned len);
        logic [31:0] a;
        int unsigned rem, off, pg, n;
        ar_t  e;
        obi_t w;
        a = src; rem = len;
        while (rem > 0) begin
            off = a % 4;
            pg  = 4096 - (a % 4096);
            n   = rem;
            if (pg < n) n = pg;
            if (64 - off < n) n = 64 - off;
            e.addr = a & 32'hFFFF_FFFC;
            e.len  = 8'((n + off - 1) / 4);
            e.off  = 2'(off);
            e.tail = 2'((off + n) % 4);
            ar_q.push_back(e);
            a = a + n; rem = rem - n;
        end
        a = dst; rem = len;
        while (rem > 0) begin
            off = a % 4;
            n   = 4 - off;
            if (rem < n) n = rem;
            w.addr = a & 32'hFFFF_FFFC;
            w.be   = '0;
            for (int unsigned i = 0; i < 4; i++) if (i >= off && i < off + n) w.be[i] = 1'b1;
            w.last = (n == rem);
            obi_q.push_back(w);
            a = a + n; rem = rem - n;
        end
    endfunction

    function automatic void push_ar(input logic [31:0] a, input int l, input int o, input int t);
        ar_t e;
        e.addr = a; e.len = 8'(l); e.off = 2'(o); e.tail = 2'(t);
        ar_q.push_back(e);
    endfunction

    function automatic void push_obi(input logic [31:0] a, input logic [3:0] be, input logic last);
        obi_t w;
        w.addr = a; w.be = be; w.last = last;
        obi_q.push_back(w);
    endfunction

    // Monitor: pops expectations on every handshake and checks payload stability while stalled.
    ar_t  ae;
    obi_t oe;
    logic        ar_hold = 1'b0, obi_hold = 1'b0;
    logic [47:0] ar_snap;
    logic [41:0] obi_snap;
    always @(negedge clk) begin
        if (!rst_n) begin
            ar_hold  = 1'b0;
            obi_hold = 1'b0;
        end else begin
            if (ar_hold && bus.ar_valid_o) begin
                checks++;
                if ({bus.ar_addr_o, bus.ar_len_o, bus.r_offset_o, bus.r_tailer_o, bus.ar_id_o} != ar_snap) begin
                    failures++;
                    $display("FAIL ar_stable got=%h required=%h", {bus.ar_addr_o, bus.ar_len_o, bus.r_offset_o, bus.r_tailer_o, bus.ar_id_o}, ar_snap);
                end
            end
            if (obi_hold && bus.obi_valid_o) begin
                checks++;
                if ({bus.obi_addr_o, bus.obi_be_o, bus.obi_aid_o, bus.obi_last_o, bus.obi_super_last_o} != obi_snap) begin
                    failures++;
                    $display("FAIL obi_stable got=%h required=%h", {bus.obi_addr_o, bus.obi_be_o, bus.obi_aid_o, bus.obi_last_o, bus.obi_super_last_o}, obi_snap);
                end
            end
            ar_hold  = bus.ar_valid_o && !bus.ar_ready_i && !bus.kill_i && !bus.flush_i;
            obi_hold = bus.obi_valid_o && !bus.obi_ready_i && !bus.kill_i && !bus.flush_i;
            ar_snap  = {bus.ar_addr_o, bus.ar_len_o, bus.r_offset_o, bus.r_tailer_o, bus.ar_id_o};
            obi_snap = {bus.obi_addr_o, bus.obi_be_o, bus.obi_aid_o, bus.obi_last_o, bus.obi_super_last_o};

            if (bus.ar_valid_o && bus.ar_ready_i) begin
                ar_hs++;
                checks++;
                if (ar_q.size() == 0) begin
                    failures++;
                    $display("FAIL ar_unexpected got addr=%h len=%0d required none", bus.ar_addr_o, bus.ar_len_o);
                end else begin
                    ae = ar_q.pop_front();
                    if (bus.ar_addr_o !== ae.addr || bus.ar_len_o !== ae.len || bus.r_offset_o !== ae.off ||
                        bus.r_tailer_o !== ae.tail || bus.ar_id_o !== cur_id || bus.r_shift_o !== cur_rsh) begin
                        failures++;
                        $display("FAIL ar_burst got addr=%h len=%0d off=%0d tail=%0d id=%0d rsh=%0d required addr=%h len=%0d off=%0d tail=%0d id=%0d rsh=%0d",
                                 bus.ar_addr_o, bus.ar_len_o, bus.r_offset_o, bus.r_tailer_o, bus.ar_id_o, bus.r_shift_o,
                                 ae.addr, ae.len, ae.off, ae.tail, cur_id, cur_rsh);
                    end
                end
            end
            if (bus.obi_valid_o && bus.obi_ready_i) begin
                obi_hs++;
                checks++;
                if (obi_q.size() == 0) begin
                    failures++;
                    $display("FAIL obi_unexpected got addr=%h be=%b required none", bus.obi_addr_o, bus.obi_be_o);
                end else begin
                    oe = obi_q.pop_front();
                    if (bus.obi_addr_o !== oe.addr || bus.obi_be_o !== oe.be || bus.obi_last_o !== oe.last ||
                        bus.obi_aid_o !== cur_id || bus.obi_super_last_o !== cur_last || bus.w_shift_o !== cur_wsh) begin
                        failures++;
                        $display("FAIL obi_word got addr=%h be=%b last=%b aid=%0d sl=%b wsh=%0d required addr=%h be=%b last=%b aid=%0d sl=%b wsh=%0d",
                                 bus.obi_addr_o, bus.obi_be_o, bus.obi_last_o, bus.obi_aid_o, bus.obi_super_last_o, bus.w_shift_o,
                                 oe.addr, oe.be, oe.last, cur_id, cur_last, cur_wsh);
                    end
                end
            end
        end
    end

    task automatic check_zero(input string name);
        logic [127:0] v;
        v = {bus.req_ready_o, bus.ar_valid_o, bus.ar_addr_o, bus.ar_len_o, bus.ar_id_o, bus.r_offset_o,
             bus.r_tailer_o, bus.r_shift_o, bus.w_shift_o, bus.obi_valid_o, bus.obi_addr_o, bus.obi_be_o,
             bus.obi_aid_o, bus.obi_last_o, bus.obi_super_last_o, bus.r_busy_o, bus.w_busy_o};
        checks++;
        if (v != '0) begin
            failures++;
            $display("FAIL %s outputs=%h required=0", name, v);
        end
    endtask

    task automatic issue(input logic [31:0] src, input logic [31:0] dst, input int unsigned len,
                         input logic [3:0] id, input logic last, input bit use_model);
        bit ok;
        @(posedge clk); #1;
        bus.req_src_addr_i = src;
        bus.req_dst_addr_i = dst;
        bus.req_length_i   = len;
        bus.req_id_i       = id;
        bus.req_last_i     = last;
        bus.req_valid_i    = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.req_ready_o) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL req_accept ready=0 required=1"); end
        cur_id   = id;
        cur_last = last;
        cur_rsh  = src[1:0];
        cur_wsh  = 2'((4 - int'(dst[1:0])) % 4);
        if (use_model) model(src, dst, len);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (len != 0) begin
            if (!(bus.r_busy_o && bus.w_busy_o && bus.ar_valid_o && bus.obi_valid_o) ||
                bus.r_shift_o !== cur_rsh || bus.w_shift_o !== cur_wsh) begin
                failures++;
                $display("FAIL start busy=%b%b valid=%b%b rsh=%0d wsh=%0d required busy=11 valid=11 rsh=%0d wsh=%0d",
                         bus.r_busy_o, bus.w_busy_o, bus.ar_valid_o, bus.obi_valid_o, bus.r_shift_o, bus.w_shift_o, cur_rsh, cur_wsh);
            end
        end else begin
            if (bus.r_busy_o || bus.w_busy_o || bus.ar_valid_o || bus.obi_valid_o ||
                bus.r_shift_o !== cur_rsh || bus.w_shift_o !== cur_wsh) begin
                failures++;
                $display("FAIL zero_len busy=%b%b valid=%b%b rsh=%0d wsh=%0d required busy=00 valid=00 rsh=%0d wsh=%0d",
                         bus.r_busy_o, bus.w_busy_o, bus.ar_valid_o, bus.obi_valid_o, bus.r_shift_o, bus.w_shift_o, cur_rsh, cur_wsh);
            end
        end
    endtask

    task automatic drain(input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk); #1;
            if (ar_q.size() == 0 && obi_q.size() == 0 && !bus.r_busy_o && !bus.w_busy_o) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL drain ar_left=%0d obi_left=%0d busy=%b%b required 0 0 00",
                     ar_q.size(), obi_q.size(), bus.r_busy_o, bus.w_busy_o);
            ar_q.delete();
            obi_q.delete();
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, h0;
        logic [31:0] s;
        bus.req_valid_i = 1'b0; bus.req_src_addr_i = '0; bus.req_dst_addr_i = '0;
        bus.req_length_i = '0; bus.req_id_i = '0; bus.req_last_i = 1'b0;
        bus.flush_i = 1'b0; bus.kill_i = 1'b0;

        #3;
        check_zero("reset_outputs");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready_o !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b required=1", bus.req_ready_o); end

        // Unaligned transfer with known results.
        ar_man = 1'b1; obi_man = 1'b1;
        push_ar(32'h1000, 2, 2, 0);
        push_obi(32'h2000, 4'b1110, 1'b0);
        push_obi(32'h2004, 4'b1111, 1'b0);
        push_obi(32'h2008, 4'b0111, 1'b1);
        issue(32'h1002, 32'h2001, 10, 4'd3, 1'b1, 1'b0);
        checks++;
        if (cur_rsh != 2'd2 || cur_wsh != 2'd3) begin failures++; $display("FAIL shift_calc rsh=%0d wsh=%0d required 2 3", cur_rsh, cur_wsh); end
        drain(100);

        // Page crossing on the read side.
        push_ar(32'h0FF8, 1, 0, 0);
        push_ar(32'h1000, 1, 0, 0);
        for (int i = 0; i < 4; i++) push_obi(32'h3000 + 32'(4 * i), 4'b1111, i == 3);
        issue(32'h0FF8, 32'h3000, 16, 4'd5, 1'b0, 1'b0);
        drain(100);

        // Burst cap.
        push_ar(32'h0, 15, 0, 0);
        push_ar(32'h40, 8, 0, 0);
        for (int i = 0; i < 25; i++) push_obi(32'h5000 + 32'(4 * i), 4'b1111, i == 24);
        issue(32'h0, 32'h5000, 100, 4'd9, 1'b1, 1'b0);
        drain(200);

        // Zero-length request.
        issue(32'h0000_0123, 32'h0000_0456, 0, 4'd1, 1'b0, 1'b1);
        drain(10);

        // Write backpressure while reads continue.
        ar_man = 1'b0; obi_man = 1'b1;
        issue(32'h0FF0, 32'h0103, 40, 4'd7, 1'b0, 1'b1);
        @(posedge clk); #1;
        obi_man = 1'b0; ar_man = 1'b1;
        a0 = ar_hs;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (ar_hs - a0 != 2) begin failures++; $display("FAIL ar_during_stall got=%0d required=2", ar_hs - a0); end
        @(posedge clk); #1;
        obi_man = 1'b1;
        drain(200);

        // Kill after the first write handshake.
        ar_man = 1'b0; obi_man = 1'b1;
        h0 = obi_hs;
        issue(32'h0300, 32'h0401, 40, 4'd2, 1'b1, 1'b1);
        checks++;
        if (obi_hs != h0 + 1) begin failures++; $display("FAIL kill_pre_hs got=%0d required=%0d", obi_hs - h0, 1); end
        @(posedge clk); #1 bus.kill_i = 1'b1;
        @(posedge clk); #1 bus.kill_i = 1'b0;
        ar_q.delete(); obi_q.delete();
        @(negedge clk); #1;
        checks++;
        if (bus.r_busy_o || bus.w_busy_o || !bus.req_ready_o) begin
            failures++;
            $display("FAIL kill busy=%b%b ready=%b required busy=00 ready=1", bus.r_busy_o, bus.w_busy_o, bus.req_ready_o);
        end

        // Flush held for three cycles.
        ar_man = 1'b0; obi_man = 1'b0;
        issue(32'h0010, 32'h0022, 20, 4'd4, 1'b0, 1'b1);
        @(posedge clk); #1;
        bus.flush_i = 1'b1; ar_man = 1'b1; obi_man = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            checks++;
            if (bus.ar_valid_o || bus.obi_valid_o || !bus.r_busy_o || !bus.w_busy_o || bus.req_ready_o) begin
                failures++;
                $display("FAIL flush valid=%b%b busy=%b%b ready=%b required valid=00 busy=11 ready=0",
                         bus.ar_valid_o, bus.obi_valid_o, bus.r_busy_o, bus.w_busy_o, bus.req_ready_o);
            end
        end
        @(posedge clk); #1 bus.flush_i = 1'b0;
        drain(200);

        // Reset in the middle of a transfer.
        ar_man = 1'b0; obi_man = 1'b0;
        issue(32'h0777, 32'h0888, 40, 4'd6, 1'b1, 1'b1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1 check_zero("reset_mid_transfer");
        ar_q.delete(); obi_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        ar_man = 1'b1; obi_man = 1'b1;
        issue(32'h2003, 32'h4002, 7, 4'd11, 1'b1, 1'b1);
        drain(100);

        // Randomized transfers with random ready on both sides.
        rand_rdy = 1'b1;
        for (int t = 0; t < 40; t++) begin
            s = $urandom;
            if ($urandom % 6 == 0) s = 32'hFFFF_FFC0 + 32'($urandom_range(0, 63));
            issue(s, $urandom, $urandom_range(0, 150), 4'($urandom), 1'($urandom), 1'b1);
            drain(2000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
